ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported RAM.
// Each access walks IDLE -> ACCESS -> DONE. All outputs are registered, except busy.
module ram_arbiter #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             err0,
  output logic             err1,
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] mem_out,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [WIDTH-1:0] DepthW = WIDTH'(DEPTH);

  state_e             state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               grant_q, grant_d;
  logic               we_q, we_d;
  logic [WIDTH-1:0]   addr_q, addr_d;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic               err0_q, err0_d, err1_q, err1_d;
  logic [WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [WIDTH-1:0]   mem_data_in_q, mem_data_in_d;
  logic               mem_read_en_q, mem_read_en_d;
  logic               mem_write_en_q, mem_write_en_d;

  logic               sel_gnt, sel_we, sel_oor, acc_oor;
  logic [WIDTH-1:0]   sel_addr, sel_wdata, acc_rdata;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    we_d           = we_q;
    addr_d         = addr_q;
    ack0_d         = 1'b0;
    ack1_d         = 1'b0;
    err0_d         = 1'b0;
    err1_d         = 1'b0;
    rdata0_d       = '0;
    rdata1_d       = '0;
    mem_address_d  = '0;
    mem_data_in_d  = '0;
    mem_read_en_d  = 1'b0;
    mem_write_en_d = 1'b0;

    // Tie goes to the port that did not win last time.
    sel_gnt   = (req0 && req1) ? ~last_grant_q : req1;
    sel_we    = sel_gnt ? we1 : we0;
    sel_addr  = sel_gnt ? addr1 : addr0;
    sel_wdata = sel_gnt ? wdata1 : wdata0;
    sel_oor   = (sel_addr >= DepthW);
    acc_oor   = (addr_q >= DepthW);
    acc_rdata = (!acc_oor && !we_q) ? mem_out : '0;

    case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          state_d        = StAccess;
          grant_d        = sel_gnt;
          last_grant_d   = sel_gnt;
          we_d           = sel_we;
          addr_d         = sel_addr;
          // RAM-side outputs are registered, so they are set up on the grant edge.
          mem_address_d  = sel_oor ? '0 : sel_addr;
          mem_data_in_d  = sel_oor ? '0 : sel_wdata;
          mem_write_en_d = !sel_oor && sel_we;
          mem_read_en_d  = !sel_oor && !sel_we;
        end
      end
      StAccess: begin
        state_d = StDone;
        if (grant_q) begin
          ack1_d   = 1'b1;
          err1_d   = acc_oor;
          rdata1_d = acc_rdata;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = acc_oor;
          rdata0_d = acc_rdata;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      grant_q        <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= '0;
      ack0_q         <= 1'b0;
      ack1_q         <= 1'b0;
      err0_q         <= 1'b0;
      err1_q         <= 1'b0;
      rdata0_q       <= '0;
      rdata1_q       <= '0;
      mem_address_q  <= '0;
      mem_data_in_q  <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      ack0_q         <= ack0_d;
      ack1_q         <= ack1_d;
      err0_q         <= err0_d;
      err1_q         <= err1_d;
      rdata0_q       <= rdata0_d;
      rdata1_q       <= rdata1_d;
      mem_address_q  <= mem_address_d;
      mem_data_in_q  <= mem_data_in_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
    end
  end

  assign ack0         = ack0_q;
  assign ack1         = ack1_q;
  assign err0         = err0_q;
  assign err1         = err1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign mem_address  = mem_address_q;
  assign mem_data_in  = mem_data_in_q;
  assign mem_read_en  = mem_read_en_q;
  assign mem_write_en = mem_write_en_q;
  assign busy         = (state_q != StIdle);

endmodule
